// File: rtl/ixc_readback_26.sv
// ----------------------------------------------------------------------------
// ixc_readback_26
//
// Read side of an emulation assign connection. On a capture request the
// observed net R is snapshotted into a shadow register. The snapshot is then
// streamed to the host debug channel as NW words of CHUNK bits over a
// valid/ready handshake, least-significant chunk first. R is only ever
// sampled, never driven.
//
// Parameters
//   WIDTH      width of the observed bus (default 26)
//   CHUNK      width of each output word (default 8)
//   NW         derived word count, ceil(WIDTH/CHUNK); not overridable
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   R          observed net, sampled at the capture edge only
//   cap_req    capture request, sampled every cycle
//   ovr_clr    clears the sticky overrun flag
//   out_data   current word; the last word is zero-padded in its MSBs
//   out_valid  out_data is valid (high for the whole of SEND)
//   out_ready  host accepts the current word
//   out_last   current word is word NW-1
//   cap_busy   a capture is in flight
//   cap_count  completed captures, wraps modulo 2^16
//   overrun    sticky, set when a capture request is dropped
// ----------------------------------------------------------------------------
module ixc_readback_26 #(
  parameter int WIDTH = 26,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] R,
  input  logic             cap_req,
  input  logic             ovr_clr,
  output logic [CHUNK-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             cap_busy,
  output logic [15:0]      cap_count,
  output logic             overrun
);

  localparam int NW   = (WIDTH + CHUNK - 1) / CHUNK;
  // A one-word stream still needs a legal index register.
  localparam int IDXW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NW - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               ovr_q, ovr_d;

  logic               xfer;
  logic               xfer_last;
  logic               drop;
  logic [NW*CHUNK-1:0] padded;

  // --------------------------------------------------------------------------
  // Output decode: registered state only, no input reaches an output.
  // --------------------------------------------------------------------------
  assign out_valid = (state_q == SEND);
  assign cap_busy  = (state_q == SEND);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign cap_count = cnt_q;
  assign overrun   = ovr_q;

  // Bits at or above WIDTH in the final word read as zero.
  always_comb begin
    padded            = '0;
    padded[WIDTH-1:0] = shadow_q;
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int i = 0; i < NW; i++) begin
        if (idx_q == IDXW'(i)) out_data = padded[i*CHUNK +: CHUNK];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  assign xfer      = out_valid && out_ready;
  assign xfer_last = xfer && out_last;
  // A request on the final-handshake edge is a back-to-back capture, not a drop.
  assign drop      = (state_q == SEND) && cap_req && !xfer_last;

  always_comb begin
    // NOTE: every signal driven here gets a hold default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;

    case (state_q)
      IDLE: begin
        if (cap_req) begin
          state_d  = SEND;
          shadow_d = R;
          idx_d    = '0;
        end
      end
      SEND: begin
        if (xfer_last) begin
          cnt_d = cnt_q + 16'd1;
          idx_d = '0;
          if (cap_req) shadow_d = R;
          else         state_d  = IDLE;
        end else if (xfer) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set wins over clear on the same edge.
    if (drop)         ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: the shadow register is reset along with the control state so that
  // a reset leaves no stale snapshot visible on out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule

// File: tb/tb_ixc_readback_26.sv
// ----------------------------------------------------------------------------
// tb_ixc_readback_26
//
// Directed bench for ixc_readback_26. A vector table covers single capture,
// dropped requests and overrun set/clear priority; hand-written sequences
// cover backpressure with snapshot hold, back-to-back capture, reset in the
// middle of a capture, and cap_count wrap (on a one-word instance so that
// 65536 captures take 65536 cycles).
// ----------------------------------------------------------------------------
module tb_ixc_readback_26;

  logic        clk;
  logic        rst_n;
  logic [25:0] r;
  logic        cap_req;
  logic        ovr_clr;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        cap_busy;
  logic [15:0] cap_count;
  logic        overrun;

  // One-word instance used for the counter wrap run.
  logic [7:0]  w_r;
  logic        w_cap_req;
  logic        w_ready;
  logic [7:0]  w_data;
  logic        w_valid;
  logic        w_last;
  logic        w_busy;
  logic [15:0] w_count;
  logic        w_overrun;

  int total = 0;
  int bad   = 0;

  ixc_readback_26 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .R         (r),
    .cap_req   (cap_req),
    .ovr_clr   (ovr_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .cap_busy  (cap_busy),
    .cap_count (cap_count),
    .overrun   (overrun)
  );

  ixc_readback_26 #(.WIDTH(8), .CHUNK(8)) u_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .R         (w_r),
    .cap_req   (w_cap_req),
    .ovr_clr   (1'b0),
    .out_data  (w_data),
    .out_valid (w_valid),
    .out_ready (w_ready),
    .out_last  (w_last),
    .cap_busy  (w_busy),
    .cap_count (w_count),
    .overrun   (w_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        cap_req;
    logic        out_ready;
    logic        ovr_clr;
    logic [25:0] r;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic        busy;
    logic [15:0] cnt;
    logic        ovr;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic valid, input logic [7:0] data,
                            input logic last, input logic busy, input logic [15:0] cnt,
                            input logic ovr);
    check({tag, " valid"},   32'(out_valid), 32'(valid));
    check({tag, " data"},    32'(out_data),  32'(data));
    check({tag, " last"},    32'(out_last),  32'(last));
    check({tag, " busy"},    32'(cap_busy),  32'(busy));
    check({tag, " count"},   32'(cap_count), 32'(cnt));
    check({tag, " overrun"}, 32'(overrun),   32'(ovr));
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [25:0] R_A = 26'h2A5C3F1;
  localparam logic [25:0] R_B = 26'h1234567;
  localparam logic [25:0] R_F = 26'h3FFFFFF;

  logic [7:0] words_a [4];

  initial begin
    words_a[0] = 8'hF1;
    words_a[1] = 8'hC3;
    words_a[2] = 8'hA5;
    words_a[3] = 8'h02;

    // cap_req, ready, ovr_clr, R, | valid, data, last, busy, count, overrun
    // Single capture.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, R_A, 1'b1, 8'hF1, 1'b0, 1'b1, 16'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, R_A, 1'b1, 8'hC3, 1'b0, 1'b1, 16'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, R_A, 1'b1, 8'hA5, 1'b0, 1'b1, 16'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, R_A, 1'b1, 8'h02, 1'b1, 1'b1, 16'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, R_A, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1, 1'b0};
    // Dropped request the cycle after capture; the capture completes unchanged.
    tbl[5]  = '{1'b1, 1'b1, 1'b0, R_A, 1'b1, 8'hF1, 1'b0, 1'b1, 16'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, R_B, 1'b1, 8'hC3, 1'b0, 1'b1, 16'd1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, R_B, 1'b1, 8'hA5, 1'b0, 1'b1, 16'd1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, R_B, 1'b1, 8'h02, 1'b1, 1'b1, 16'd1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, R_B, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, R_B, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2, 1'b0};
    // Clear coincident with a new drop: set wins.
    tbl[11] = '{1'b1, 1'b0, 1'b0, R_A, 1'b1, 8'hF1, 1'b0, 1'b1, 16'd2, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, R_A, 1'b1, 8'hF1, 1'b0, 1'b1, 16'd2, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, R_A, 1'b1, 8'hC3, 1'b0, 1'b1, 16'd2, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, R_A, 1'b1, 8'hA5, 1'b0, 1'b1, 16'd2, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, R_A, 1'b1, 8'h02, 1'b1, 1'b1, 16'd2, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, R_A, 1'b0, 8'h00, 1'b0, 1'b0, 16'd3, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b1, R_A, 1'b0, 8'h00, 1'b0, 1'b0, 16'd3, 1'b0};

    rst_n     = 1'b0;
    r         = '0;
    cap_req   = 1'b0;
    ovr_clr   = 1'b0;
    out_ready = 1'b0;
    w_r       = 8'hA5;
    w_cap_req = 1'b0;
    w_ready   = 1'b0;

    // Reset state.
    #12;
    check_outs("reset", 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 18; i++) begin
      cap_req   = tbl[i].cap_req;
      out_ready = tbl[i].out_ready;
      ovr_clr   = tbl[i].ovr_clr;
      r         = tbl[i].r;
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].valid, tbl[i].data, tbl[i].last,
                 tbl[i].busy, tbl[i].cnt, tbl[i].ovr);
    end
    cap_req = 1'b0;
    ovr_clr = 1'b0;

    // Backpressure: ready 0,0,1 per word; R changes after the capture edge.
    r         = R_A;
    cap_req   = 1'b1;
    out_ready = 1'b0;
    tick();
    cap_req = 1'b0;
    r       = R_B;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 3; k++) begin
        out_ready = (k == 2);
        check($sformatf("bp w%0d c%0d data", w, k), 32'(out_data), 32'(words_a[w]));
        check($sformatf("bp w%0d c%0d last", w, k), 32'(out_last), 32'(w == 3));
        check($sformatf("bp w%0d c%0d valid", w, k), 32'(out_valid), 32'd1);
        tick();
      end
    end
    out_ready = 1'b0;
    check("bp done valid", 32'(out_valid), 32'd0);
    check("bp done count", 32'(cap_count), 32'd4);

    // Back-to-back: request on the last handshake, no idle cycle between.
    r         = R_A;
    cap_req   = 1'b1;
    out_ready = 1'b1;
    tick();
    cap_req = 1'b0;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("b2b first w%0d", w), 32'(out_data), 32'(words_a[w]));
      tick();
    end
    check("b2b first w3", 32'(out_data), 32'h02);
    check("b2b first last", 32'(out_last), 32'd1);
    cap_req = 1'b1;
    r       = R_F;
    tick();
    cap_req = 1'b0;
    r       = R_B;
    check("b2b no idle valid", 32'(out_valid), 32'd1);
    check("b2b count mid", 32'(cap_count), 32'd5);
    check("b2b overrun", 32'(overrun), 32'd0);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("b2b second w%0d", w), 32'(out_data), (w == 3) ? 32'h03 : 32'hFF);
      check($sformatf("b2b second last%0d", w), 32'(out_last), 32'(w == 3));
      tick();
    end
    out_ready = 1'b0;
    check("b2b end valid", 32'(out_valid), 32'd0);
    check("b2b end count", 32'(cap_count), 32'd6);

    // Reset after word 1 has transferred.
    r         = R_A;
    cap_req   = 1'b1;
    out_ready = 1'b1;
    tick();
    cap_req = 1'b0;
    tick();
    check("pre-reset data", 32'(out_data), 32'hC3);
    rst_n = 1'b0;
    #1;
    check_outs("mid reset", 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    check("post reset idle", 32'(out_valid), 32'd0);
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    check_outs("restart w0", 1'b1, 8'hF1, 1'b0, 1'b1, 16'd0, 1'b0);
    tick();
    check("restart w1", 32'(out_data), 32'hC3);
    out_ready = 1'b0;

    // Counter wrap on the one-word instance: capture edge, then one
    // completion per cycle while request and ready stay high.
    check("wrap start count", 32'(w_count), 32'd0);
    w_cap_req = 1'b1;
    w_ready   = 1'b1;
    tick();
    check("wrap first data", 32'(w_data), 32'hA5);
    check("wrap first last", 32'(w_last), 32'd1);
    repeat (65535) tick();
    check("wrap at ffff", 32'(w_count), 32'hFFFF);
    tick();
    check("wrap to zero", 32'(w_count), 32'h0000);
    check("wrap overrun", 32'(w_overrun), 32'd0);
    check("wrap busy", 32'(w_busy), 32'd1);
    w_cap_req = 1'b0;
    tick();
    check("wrap final count", 32'(w_count), 32'd1);
    check("wrap idle", 32'(w_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
